// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared FSM encoding, read-latency bounds and expected-word helper
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int MAX_DATA_W = 64;

    // Callers size-cast the result down to their own data width.
    function automatic logic [MAX_DATA_W-1:0] expand_bit(input logic b);
        return {MAX_DATA_W{b}};
    endfunction

endpackage

// File: rtl/bist_response_analyzer_if.sv
// rtl/bist_response_analyzer_if.sv - controller/memory side bundle of the BIST response analyzer
interface bist_response_analyzer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              read_en;
    logic              data_bit;
    logic [ADDR_W-1:0] addr;
    logic              test_end;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              status;
    logic [CNT_W-1:0]  err_cnt;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_syn;

    modport master (
        output start, read_en, data_bit, addr, test_end, rdata,
        input  done, status, err_cnt, fail_valid, fail_addr, fail_syn
    );

    modport slave (
        input  start, read_en, data_bit, addr, test_end, rdata,
        output done, status, err_cnt, fail_valid, fail_addr, fail_syn
    );
endinterface

// File: rtl/bist_rd_pipe.sv
// rtl/bist_rd_pipe.sv - valid-tagged delay line aligning {addr, data_bit} with returning read data
module bist_rd_pipe #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_bit,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_bit
);
    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  bits;
    logic [ADDR_W-1:0] addrs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld  <= '0;
            bits <= '0;
            for (int i = 0; i < DEPTH; i++) addrs[i] <= '0;
        end else begin
            vld[0]   <= push;
            bits[0]  <= in_bit;
            addrs[0] <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i]   <= vld[i-1];
                bits[i]  <= bits[i-1];
                addrs[i] <= addrs[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_bit   = bits[DEPTH-1];
    assign out_addr  = addrs[DEPTH-1];
endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - compares March read data with the background word; BIST_FAIL_LOG_EN adds the first-fail record
module bist_response_analyzer
    import bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    bist_response_analyzer_if.slave  bus
);
    // Out-of-range latencies are clamped so the delay line and drain counter stay consistent.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    bist_state_t       state, state_next;
    logic              push, load_drain, clr, mismatch;
    logic [2:0]        drain_cnt;
    logic              pv, pb;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] exp_word, syn;
    logic [CNT_W-1:0]  err_cnt, err_next;
    logic              done_r, status_r;

    assign clr = bus.start;

    bist_rd_pipe #(.ADDR_W(ADDR_W), .DEPTH(LAT)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .in_addr   (bus.addr),
        .in_bit    (bus.data_bit),
        .out_valid (pv),
        .out_addr  (pa),
        .out_bit   (pb)
    );

    assign exp_word = DATA_W'(expand_bit(pb));
    assign syn      = bus.rdata ^ exp_word;
    assign mismatch = pv && (state == RUN || state == DRAIN) && !bus.start && (syn != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        push       = 1'b0;
        load_drain = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_next = RUN;
            RUN: begin
                if (!bus.start) begin
                    push = bus.read_en;
                    if (bus.test_end) begin
                        state_next = DRAIN;
                        load_drain = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.start)             state_next = RUN;
                else if (drain_cnt == '0)  state_next = DONE;
            end
            DONE:  if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                drain_cnt <= '0;
        else if (load_drain)                    drain_cnt <= 3'(LAT - 1);
        else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - 3'd1;
    end

    always_comb begin
        err_next = err_cnt;
        if (clr)                               err_next = '0;
        else if (mismatch && err_cnt != '1)    err_next = err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt <= '0;
        else     err_cnt <= err_next;
    end

    // Status is taken from err_next so the last drained read is included.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            done_r   <= 1'b0;
            status_r <= 1'b0;
        end else if (state == DRAIN && state_next == DONE) begin
            done_r   <= 1'b1;
            status_r <= (err_next == '0);
        end
    end

    assign bus.done    = done_r;
    assign bus.status  = status_r;
    assign bus.err_cnt = err_cnt;

`ifdef BIST_FAIL_LOG_EN
    logic              fv_r;
    logic [ADDR_W-1:0] fa_r;
    logic [DATA_W-1:0] fs_r;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            fv_r <= 1'b0;
            fa_r <= '0;
            fs_r <= '0;
        end else if (mismatch && !fv_r) begin
            fv_r <= 1'b1;
            fa_r <= pa;
            fs_r <= syn;
        end
    end

    assign bus.fail_valid = fv_r;
    assign bus.fail_addr  = fa_r;
    assign bus.fail_syn   = fs_r;
`else
    logic unused_fail_addr;
    assign unused_fail_addr = &{1'b0, pa};

    assign bus.fail_valid = 1'b0;
    assign bus.fail_addr  = '0;
    assign bus.fail_syn   = '0;
`endif
endmodule
